// File: rtl/pipe_stage_hs.sv
// Valid/ready pipeline register stage with optional skid buffer and flush.
// Define PIPE_STAGE_SKID_EN to add the skid register and registered in_ready_o.
module pipe_stage_hs #(
  parameter int               DATA_W       = 32,
  parameter int               PC_W         = 32,
  parameter logic [DATA_W-1:0] NOP_VAL     = DATA_W'(32'h0000_0013),
  parameter bit               FLUSH_CLR_PC = 1'b1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [PC_W-1:0]   pc_i,
  input  logic [DATA_W-1:0] instr_i,
  input  logic              flush_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [PC_W-1:0]   pc_o,
  output logic [DATA_W-1:0] instr_o,
  output logic [1:0]        occ_o
);

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  state_t            state;
  logic              out_valid_q;
  logic [PC_W-1:0]   pc_q;
  logic [DATA_W-1:0] instr_q;
  logic              take_in;
  logic              take_out;

`ifdef PIPE_STAGE_SKID_EN
  logic              ready_q;
  logic [PC_W-1:0]   skid_pc_q;
  logic [DATA_W-1:0] skid_instr_q;
  assign in_ready_o = ready_q;
`else
  assign in_ready_o = !out_valid_q || out_ready_i;
`endif

  assign take_in  = in_valid_i && in_ready_o;
  assign take_out = out_valid_q && out_ready_i;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= EMPTY;
      out_valid_q <= 1'b0;
      pc_q        <= '0;
      instr_q     <= NOP_VAL;
`ifdef PIPE_STAGE_SKID_EN
      ready_q     <= 1'b1;
`endif
    end else if (flush_i) begin
      // Flush wins over any same-cycle transfer; the incoming entry is dropped.
      state       <= EMPTY;
      out_valid_q <= 1'b0;
      instr_q     <= NOP_VAL;
      if (FLUSH_CLR_PC) pc_q <= '0;
`ifdef PIPE_STAGE_SKID_EN
      ready_q     <= 1'b1;
`endif
    end else begin
      case (state)
        EMPTY: begin
          if (take_in) begin
            pc_q        <= pc_i;
            instr_q     <= instr_i;
            out_valid_q <= 1'b1;
            state       <= FULL;
          end
        end
        FULL: begin
          if (take_in && take_out) begin
            pc_q    <= pc_i;
            instr_q <= instr_i;
          end else if (take_out) begin
            state       <= EMPTY;
            out_valid_q <= 1'b0;
            pc_q        <= '0;
            instr_q     <= NOP_VAL;
          end
`ifdef PIPE_STAGE_SKID_EN
          else if (take_in) begin
            skid_pc_q    <= pc_i;
            skid_instr_q <= instr_i;
            state        <= SKID;
            ready_q      <= 1'b0;
          end
`endif
        end
`ifdef PIPE_STAGE_SKID_EN
        SKID: begin
          if (take_out) begin
            pc_q    <= skid_pc_q;
            instr_q <= skid_instr_q;
            state   <= FULL;
            ready_q <= 1'b1;
          end
        end
`endif
        default: begin
          state       <= EMPTY;
          out_valid_q <= 1'b0;
          pc_q        <= '0;
          instr_q     <= NOP_VAL;
`ifdef PIPE_STAGE_SKID_EN
          ready_q     <= 1'b1;
`endif
        end
      endcase
    end
  end

  assign out_valid_o = out_valid_q;
  assign pc_o        = pc_q;
  assign instr_o     = instr_q;
  assign occ_o       = state;

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Scoreboard testbench for pipe_stage_hs; works with or without PIPE_STAGE_SKID_EN.
module tb_pipe_stage_hs;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0;
  logic [31:0] pc_in = '0, instr_in = '0;
  logic        in_ready, out_valid;
  logic [31:0] pc_out, instr_out;
  logic [1:0]  occ;

  logic        h_valid = 1'b0, h_ordy = 1'b0, h_flush = 1'b0;
  logic [31:0] h_pc = '0, h_instr = '0;
  logic        h_in_ready, h_out_valid;
  logic [31:0] h_pc_out, h_instr_out;
  logic [1:0]  h_occ;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb[$];
  int pushed, popped;
  logic        last_stall;
  logic [31:0] last_pc, last_instr;

  always #5 clk = ~clk;

  pipe_stage_hs dut (
    .clk(clk), .rstn(rstn), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .pc_i(pc_in), .instr_i(instr_in), .flush_i(flush), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .pc_o(pc_out), .instr_o(instr_out), .occ_o(occ));

  pipe_stage_hs #(.FLUSH_CLR_PC(1'b0)) dut_h (
    .clk(clk), .rstn(rstn), .in_valid_i(h_valid), .in_ready_o(h_in_ready),
    .pc_i(h_pc), .instr_i(h_instr), .flush_i(h_flush), .out_valid_o(h_out_valid),
    .out_ready_i(h_ordy), .pc_o(h_pc_out), .instr_o(h_instr_out), .occ_o(h_occ));

  // One clock of stimulus; the scoreboard tracks accepted and delivered entries.
  task automatic step(input logic v, input logic [31:0] p, input logic [31:0] ins,
                      input logic ordy, input logic fl);
    logic [63:0] exp;
    @(negedge clk);
    in_valid = v; pc_in = p; instr_in = ins; out_ready = ordy; flush = fl;
    #1;
    last_stall = out_valid && !ordy;
    last_pc = pc_out; last_instr = instr_out;
    if (!rstn || fl) begin
      sb.delete();
    end else begin
      if (out_valid && ordy) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_extra: got pc=%h instr=%h, expected no output", pc_out, instr_out);
        end else begin
          exp = sb.pop_front();
          popped++;
          if ({pc_out, instr_out} !== exp) begin
            errors++;
            $display("FAIL sb_data: got %h, expected %h", {pc_out, instr_out}, exp);
          end
        end
      end
      if (v && in_ready) begin
        sb.push_back({p, ins});
        pushed++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, '0, '0, ordy, 1'b0);
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    idle(1'b0); idle(1'b0);
    rstn = 1'b1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b, expected 0", out_valid); end
    checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h, expected 0", pc_out); end
    checks++; if (instr_out !== NOP) begin errors++; $display("FAIL rst_instr: got %h, expected %h", instr_out, NOP); end
    checks++; if (occ !== 2'd0) begin errors++; $display("FAIL rst_occ: got %0d, expected 0", occ); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b, expected 1", in_ready); end
  endtask

  task automatic test_single;
    step(1'b1, 32'h100, 32'h0050_0093, 1'b1, 1'b0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b, expected 1", out_valid); end
    checks++; if (pc_out !== 32'h100) begin errors++; $display("FAIL single_pc: got %h, expected 100", pc_out); end
    checks++; if (instr_out !== 32'h0050_0093) begin errors++; $display("FAIL single_instr: got %h, expected 00500093", instr_out); end
    checks++; if (occ !== 2'd1) begin errors++; $display("FAIL single_occ: got %0d, expected 1", occ); end
    idle(1'b1);
    checks++; if ({out_valid, pc_out, instr_out} !== {1'b0, 32'h0, NOP}) begin
      errors++; $display("FAIL drain_empty: got v=%b pc=%h instr=%h, expected v=0 pc=0 instr=%h", out_valid, pc_out, instr_out, NOP);
    end
  endtask

  task automatic test_skid;
    step(1'b1, 32'h100, 32'hA100, 1'b0, 1'b0);
    step(1'b1, 32'h104, 32'hA104, 1'b0, 1'b0);
`ifdef PIPE_STAGE_SKID_EN
    checks++; if (occ !== 2'd2) begin errors++; $display("FAIL skid_occ: got %0d, expected 2", occ); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL skid_ready: got %b, expected 0", in_ready); end
    checks++; if (pc_out !== 32'h100) begin errors++; $display("FAIL skid_first: got %h, expected 100", pc_out); end
    idle(1'b1);
    checks++; if ({out_valid, pc_out} !== {1'b1, 32'h104}) begin errors++; $display("FAIL skid_second: got v=%b pc=%h, expected v=1 pc=104", out_valid, pc_out); end
    idle(1'b1);
`else
    checks++; if (occ !== 2'd1) begin errors++; $display("FAIL noskid_occ: got %0d, expected 1", occ); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL noskid_ready: got %b, expected 0", in_ready); end
    checks++; if (pc_out !== 32'h100) begin errors++; $display("FAIL noskid_hold: got %h, expected 100", pc_out); end
    idle(1'b1);
`endif
    checks++; if (sb.size() != 0 || out_valid !== 1'b0) begin errors++; $display("FAIL skid_drain: got left=%0d v=%b, expected 0 and 0", sb.size(), out_valid); end
  endtask

  task automatic test_flush;
    step(1'b1, 32'h100, 32'hB100, 1'b0, 1'b0);
    step(1'b1, 32'h104, 32'hB104, 1'b0, 1'b0);
    step(1'b1, 32'h108, 32'hB108, 1'b0, 1'b1);
    checks++; if (occ !== 2'd0) begin errors++; $display("FAIL flush_occ: got %0d, expected 0", occ); end
    checks++; if ({out_valid, pc_out, instr_out} !== {1'b0, 32'h0, NOP}) begin
      errors++; $display("FAIL flush_out: got v=%b pc=%h instr=%h, expected v=0 pc=0 instr=%h", out_valid, pc_out, instr_out, NOP);
    end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b, expected 1", in_ready); end
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_leak: got v=%b pc=%h, expected v=0", out_valid, pc_out); end
    end
  endtask

  task automatic test_flush_hold;
    @(negedge clk); h_valid = 1'b1; h_pc = 32'h200; h_instr = 32'hC200; h_ordy = 1'b0;
    @(negedge clk); h_valid = 1'b0; h_flush = 1'b1;
    checks++; if ({h_out_valid, h_pc_out} !== {1'b1, 32'h200}) begin errors++; $display("FAIL hold_load: got v=%b pc=%h, expected v=1 pc=200", h_out_valid, h_pc_out); end
    @(negedge clk); h_flush = 1'b0;
    checks++; if (h_pc_out !== 32'h200) begin errors++; $display("FAIL hold_pc: got %h, expected 200", h_pc_out); end
    checks++; if (h_instr_out !== NOP) begin errors++; $display("FAIL hold_instr: got %h, expected %h", h_instr_out, NOP); end
    checks++; if (h_out_valid !== 1'b0) begin errors++; $display("FAIL hold_valid: got %b, expected 0", h_out_valid); end
  endtask

  task automatic test_reset_mid;
    step(1'b1, 32'h100, 32'hD100, 1'b0, 1'b0);
    step(1'b1, 32'h104, 32'hD104, 1'b0, 1'b0);
    rstn = 1'b0;
    idle(1'b1);
    rstn = 1'b1;
    checks++; if ({out_valid, pc_out, instr_out, occ, in_ready} !== {1'b0, 32'h0, NOP, 2'd0, 1'b1}) begin
      errors++; $display("FAIL rstmid: got v=%b pc=%h instr=%h occ=%0d rdy=%b, expected reset values", out_valid, pc_out, instr_out, occ, in_ready);
    end
    step(1'b1, 32'h300, 32'hD300, 1'b1, 1'b0);
    checks++; if ({out_valid, pc_out, instr_out} !== {1'b1, 32'h300, 32'hD300}) begin
      errors++; $display("FAIL rstmid_push: got v=%b pc=%h instr=%h, expected v=1 pc=300 instr=0000d300", out_valid, pc_out, instr_out);
    end
    idle(1'b1);
  endtask

  task automatic test_random;
    int cyc;
    pushed = 0; popped = 0; cyc = 0;
    while ((pushed < 1000 || sb.size() != 0) && cyc < 20000) begin
      logic v;
      v = (pushed < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
      step(v, 32'h1000 + 32'(pushed) * 4, $urandom, 1'($urandom_range(0, 3) != 0), 1'b0);
      if (last_stall) begin
        checks++;
        if ({pc_out, instr_out} !== {last_pc, last_instr}) begin
          errors++; $display("FAIL stall_stable: got %h/%h, expected %h/%h", pc_out, instr_out, last_pc, last_instr);
        end
      end
      cyc++;
    end
    checks++; if (cyc >= 20000) begin errors++; $display("FAIL rand_timeout: got %0d cycles, expected under 20000", cyc); end
    checks++; if (popped != 1000) begin errors++; $display("FAIL rand_count: got %0d delivered, expected 1000", popped); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_skid();
    test_flush();
    test_flush_hold();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
